// File: rtl/neuron_wb_pkg.sv
// Shared types and helpers for the neuron write-back path: FSM states,
// default widths and the shift/ReLU/saturate activation.
package neuron_wb_pkg;

  localparam int ACC_W_DEF  = 16;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int SHIFT_DEF  = 4;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } wb_state_e;

  // Arithmetic shift, clamp negatives to zero, saturate to the largest
  // positive value a signed data_w-bit word can hold.
  function automatic logic [31:0] activate(input logic signed [31:0] acc,
                                           input int shift,
                                           input int data_w);
    logic signed [31:0] s;
    logic signed [31:0] max_v;
    s     = acc >>> shift;
    max_v = (32'sd1 <<< (data_w - 1)) - 32'sd1;
    if (s < 32'sd0) return '0;
    if (s > max_v) return max_v;
    return s;
  endfunction

endpackage

// File: rtl/neuron_writeback_if.sv
// MAC result stream plus neuron RAM write port, bundled for the write-back block.
interface neuron_writeback_if
  import neuron_wb_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  // acc stream: a word transfers on a rising edge where acc_valid && acc_ready;
  // the source holds acc_data stable while acc_valid is high and unaccepted.
  logic              acc_valid;
  logic [ACC_W-1:0]  acc_data;
  logic              acc_ready;
  logic              wr_grant;
  logic              wre;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;

  modport master (
    output acc_valid, acc_data, wr_grant,
    input  acc_ready, wre, write_address, write_data
  );

  modport slave (
    input  acc_valid, acc_data, wr_grant,
    output acc_ready, wre, write_address, write_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding activated results until the RAM port is granted.
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wptr;
  logic [PW:0]  rptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= din;
  end

  assign head  = mem[rptr[PW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

endmodule

// File: rtl/neuron_writeback.sv
// Takes MAC accumulations, activates them, and commits one layer of results
// to consecutive neuron RAM addresses, pulsing done once the layer is written.
module neuron_writeback
  import neuron_wb_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] write_base,
  input  logic [ADDR_W-1:0] Nk,
  output logic              busy,
  output logic              done,
  output wb_state_e         state_dbg,
  neuron_writeback_if.slave bus
);
  wb_state_e          state, state_next;
  logic [ADDR_W-1:0]  base_q, nk_q, accepted, written;
  logic               clear, push, pop, full, empty;
  logic signed [31:0] acc_ext;
  logic [DATA_W-1:0]  act_y, head;

  assign acc_ext       = {{(32-ACC_W){bus.acc_data[ACC_W-1]}}, bus.acc_data};
  assign act_y         = DATA_W'(activate(acc_ext, SHIFT, DATA_W));
  assign bus.acc_ready = (state == ST_ACTIVE) && !full && (accepted < nk_q);
  assign push          = bus.acc_valid && bus.acc_ready;
  assign pop           = (state == ST_ACTIVE) && !empty && bus.wr_grant;
  // busy stays high through the done pulse so the controller never sees a gap.
  assign busy          = (state != ST_IDLE) || done;
  assign state_dbg     = state;

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = (Nk == '0) ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (pop && (written + ADDR_W'(1) == nk_q)) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q   <= '0;
      nk_q     <= '0;
      accepted <= '0;
      written  <= '0;
    end else if (clear) begin
      base_q   <= write_base;
      nk_q     <= Nk;
      accepted <= '0;
      written  <= '0;
    end else begin
      if (push) accepted <= accepted + ADDR_W'(1);
      if (pop)  written  <= written + ADDR_W'(1);
    end
  end

  // Address wraps naturally modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.wre           <= 1'b0;
      bus.write_address <= '0;
      bus.write_data    <= '0;
    end else begin
      bus.wre <= pop;
      if (pop) begin
        bus.write_address <= base_q + written;
        bus.write_data    <= head;
      end
    end
  end

  wb_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (act_y),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_neuron_writeback.sv
// Bench for neuron_writeback: activation table, hand-written corner sequences
// and randomized layers scored against an arithmetic reference model.
module tb_neuron_writeback;
  import neuron_wb_pkg::*;

  localparam int ACC_W  = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int SHIFT  = 4;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] write_base;
  logic [ADDR_W-1:0] nk;
  logic              busy;
  logic              done;
  wb_state_e         state_dbg;

  neuron_writeback_if #(.ACC_W(ACC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  neuron_writeback #(
    .ACC_W(ACC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SHIFT(SHIFT), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .write_base (write_base),
    .Nk         (nk),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg),
    .bus        (bus)
  );

  typedef struct {
    logic [15:0] acc;
    logic [7:0]  y;
  } vec_t;

  vec_t        vecs[12];
  logic [15:0] exp_q[$];
  logic [15:0] acc_list[$];
  logic [15:0] mon_e;
  int checks = 0, failures = 0;
  int cyc = 0;
  int wr_cnt = 0, done_cnt = 0;
  int last_wr_cyc = 0, last_hs_cyc = 0, start_c = 0, fin_cyc = 0;
  int grant_pct = 100;
  int d0, w0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.wr_grant = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.wr_grant = (int'($urandom_range(0, 99)) < grant_pct);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // reference model: floor-divide by 2^SHIFT, clamp to [0, 2^(DATA_W-1)-1]
  function automatic logic [7:0] ref_act(input logic [15:0] raw);
    int v, q;
    v = int'($signed(raw));
    if (v >= 0) q = v / (2 ** SHIFT);
    else        q = -((-v + (2 ** SHIFT) - 1) / (2 ** SHIFT));
    if (q < 0) return 8'd0;
    if (q > (2 ** (DATA_W - 1)) - 1) return 8'((2 ** (DATA_W - 1)) - 1);
    return 8'(q);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  // scoreboard: every registered write must match the head of exp_q
  always @(negedge clk) begin
    if (bus.wre === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h with nothing expected",
                 bus.write_address, bus.write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr_data", {16'h0, bus.write_address, bus.write_data}, {16'h0, mon_e});
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // driver tasks: entered and left just after a rising edge
  task automatic send_acc(input logic [15:0] d);
    logic hs;
    int   n;
    bus.acc_valid = 1'b1;
    bus.acc_data  = d;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.acc_ready;
      if (hs) last_hs_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    bus.acc_valid = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: acc_ready stayed 0 for data %0h, required 1", d);
    end
  endtask

  task automatic start_layer(input logic [7:0] base, input logic [7:0] n);
    start      = 1'b1;
    write_base = base;
    nk         = n;
    start_c    = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic prep_random(input logic [7:0] base, input int n);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0:       d = 16'($urandom);
        1:       d = 16'($urandom_range(0, 2100));
        default: d = 16'(-int'($urandom_range(0, 40)));
      endcase
      acc_list.push_back(d);
      exp_q.push_back({8'(int'(base) + i), ref_act(d)});
    end
  endtask

  task automatic finish_layer(input int dstart, input bit had_writes);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: done stayed 0, required a pulse");
    end else begin
      fin_cyc = cyc;
      chk("busy_at_done", busy, 1);
      if (had_writes) chk("done_after_last_write", fin_cyc - last_wr_cyc, 1);
      chk("pending_writes", exp_q.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      chk("done_count", done_cnt - dstart, 1);
    end
    @(posedge clk);
    #1;
    bus.acc_valid = 1'b0;
  endtask

  task automatic run_layer(input logic [7:0] base, input int n, input int gpct, input int gap);
    int ds;
    ds = done_cnt;
    grant_pct = gpct;
    start_layer(base, 8'(n));
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap)) begin
        @(posedge clk);
        #1;
      end
      send_acc(acc_list[i]);
    end
    // offer one word beyond Nk; it must never be accepted
    bus.acc_valid = 1'b1;
    bus.acc_data  = 16'($urandom);
    finish_layer(ds, n > 0);
    acc_list.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; write_base = '0; nk = '0;
    bus.acc_valid = 1'b0; bus.acc_data = '0;

    vecs[0]  = '{16'h0100, 8'd16};  vecs[1]  = '{16'hFF00, 8'd0};
    vecs[2]  = '{16'h7FFF, 8'd127}; vecs[3]  = '{16'h0000, 8'd0};
    vecs[4]  = '{16'h000F, 8'd0};   vecs[5]  = '{16'h0010, 8'd1};
    vecs[6]  = '{16'h07F0, 8'd127}; vecs[7]  = '{16'h07EF, 8'd126};
    vecs[8]  = '{16'h8000, 8'd0};   vecs[9]  = '{16'hFFFF, 8'd0};
    vecs[10] = '{16'h0800, 8'd127}; vecs[11] = '{16'h0570, 8'd87};

    repeat (2) @(negedge clk);
    chk("rst_acc_ready", bus.acc_ready, 0);
    chk("rst_wre", bus.wre, 0);
    chk("rst_write_address", bus.write_address, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // activation table: first three form the base=10 layer, the rest one more layer
    for (int i = 0; i < 3; i++) begin
      acc_list.push_back(vecs[i].acc);
      exp_q.push_back({8'(10 + i), vecs[i].y});
    end
    run_layer(8'd10, 3, 100, 0);
    for (int i = 3; i < 12; i++) begin
      acc_list.push_back(vecs[i].acc);
      exp_q.push_back({8'(100 + i - 3), vecs[i].y});
    end
    run_layer(8'd100, 9, 60, 2);

    // minimum accept-to-write latency
    d0 = done_cnt;
    grant_pct = 100;
    exp_q.push_back({8'd5, 8'd35});
    start_layer(8'd5, 8'd1);
    send_acc(16'h0235);
    begin : lat_wait
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
        @(negedge clk);
        seen = bus.wre;
      end
      chk("accept_to_write_latency", seen ? (cyc - last_hs_cyc) : 0, 2);
    end
    finish_layer(d0, 1'b1);

    // grant held low: FIFO fills, ready drops, then drains back to back
    grant_pct = 0;
    @(posedge clk); #1;
    d0 = done_cnt;
    prep_random(8'd30, 6);
    start_layer(8'd30, 8'd6);
    for (int i = 0; i < 4; i++) send_acc(acc_list[i]);
    bus.acc_valid = 1'b1;
    bus.acc_data  = acc_list[4];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_low_when_full", bus.acc_ready, 0);
      chk("no_write_without_grant", bus.wre, 0);
    end
    @(posedge clk); #1;
    grant_pct = 100;
    fork
      begin : tail_send
        send_acc(acc_list[4]);
        send_acc(acc_list[5]);
      end
      begin : cons_chk
        int run;
        bit seen;
        run = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
          @(negedge clk);
          seen = bus.wre;
        end
        if (seen) begin
          run = 1;
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!bus.wre) break;
            run++;
          end
        end
        chk("consecutive_writes", run, 4);
      end
    join
    acc_list.delete();
    bus.acc_valid = 1'b1;
    finish_layer(d0, 1'b1);

    // address wrap
    prep_random(8'd254, 4);
    run_layer(8'd254, 4, 100, 1);
    prep_random(8'd250, 10);
    run_layer(8'd250, 10, 70, 1);

    // empty layer
    d0 = done_cnt;
    w0 = wr_cnt;
    start_layer(8'd7, 8'd0);
    finish_layer(d0, 1'b0);
    chk("nk0_done_latency", fin_cyc - start_c, 2);
    chk("nk0_no_write", wr_cnt - w0, 0);

    // start while active is ignored
    d0 = done_cnt;
    grant_pct = 0;
    prep_random(8'd40, 2);
    start_layer(8'd40, 8'd2);
    start = 1'b1; write_base = 8'd99; nk = 8'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("state_active_after_restart", state_dbg, ST_ACTIVE);
    @(posedge clk); #1;
    grant_pct = 100;
    send_acc(acc_list[0]);
    send_acc(acc_list[1]);
    acc_list.delete();
    bus.acc_valid = 1'b1;
    finish_layer(d0, 1'b1);

    // reset in the middle of a layer
    w0 = wr_cnt;
    grant_pct = 100;
    prep_random(8'd60, 5);
    start_layer(8'd60, 8'd5);
    send_acc(acc_list[0]);
    send_acc(acc_list[1]);
    for (int i = 0; i < 20 && wr_cnt < w0 + 2; i++) @(negedge clk);
    chk("writes_before_reset", wr_cnt - w0, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_acc_ready", bus.acc_ready, 0);
    chk("midrst_wre", bus.wre, 0);
    chk("midrst_write_address", bus.write_address, 0);
    chk("midrst_write_data", bus.write_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_state", state_dbg, ST_IDLE);
    exp_q.delete();
    acc_list.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    prep_random(8'd20, 3);
    run_layer(8'd20, 3, 100, 0);

    // randomized layers
    for (int r = 0; r < 6; r++) begin
      logic [7:0] b;
      int n;
      b = 8'($urandom_range(0, 255));
      n = int'($urandom_range(1, 16));
      prep_random(b, n);
      run_layer(b, n, int'($urandom_range(20, 100)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_writeback.md
# neuron_writeback

Write-side companion to the neuron read path: accepts finished per-neuron accumulations from the MAC core over a valid/ready handshake, applies shift + ReLU + saturation, buffers results, and writes them into the neuron dual-port RAM write port at consecutive addresses starting from a layer's write base. One run covers one layer of `Nk` neurons. A `done` pulse tells the control unit the layer is fully committed to RAM.

## Interface
Parameters:
- `ACC_W`, 16, signed accumulator width from MAC
- `DATA_W`, 8, neuron value width stored in RAM
- `ADDR_W`, 8, neuron RAM address width
- `SHIFT`, 4, arithmetic right shift applied before activation
- `DEPTH`, 4, result FIFO depth (power of two)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin layer; sampled only in IDLE
- `write_base`  in  ADDR_W  first RAM address of layer, latched on start
- `Nk`  in  ADDR_W  neuron count of layer, latched on start
- `acc_valid`  in  1  MAC result available
- `acc_data`  in  ACC_W  signed MAC accumulation
- `acc_ready`  out  1  block accepts `acc_data` this cycle
- `wr_grant`  in  1  RAM write port available this cycle
- `wre`  out  1  RAM write enable, registered
- `write_address`  out  ADDR_W  RAM write address, registered
- `write_data`  out  DATA_W  RAM write data, registered
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse after last write

## Operation
- States: IDLE, ACTIVE, DONE.
- IDLE: `start`=1 latches `write_base`, `Nk`, clears accept/write counters, FIFO, -> ACTIVE. If `Nk`=0 -> DONE directly.
- ACTIVE: accept when `acc_valid && acc_ready`; `acc_ready` = ACTIVE && FIFO not full && accepted < `Nk`. Push is refused when full even if a pop occurs the same cycle.
- Activation: s = `acc_data` >>> SHIFT (signed); y = s<0 ? 0 : s>2^(DATA_W-1)-1 ? 2^(DATA_W-1)-1 : s. Result pushed to FIFO.
- Pop: when FIFO non-empty and `wr_grant`=1, register `wre`=1, `write_data`=head, `write_address`=(base + written) mod 2^ADDR_W; increment written. Otherwise `wre`=0, address/data hold.
- When written == `Nk` -> DONE; DONE asserts `done` for one cycle, -> IDLE.
- `start` while busy ignored. `acc_valid` outside ACTIVE ignored (ready=0).
- Reset (any time, including mid-layer): state IDLE, FIFO empty, counters 0; writes already issued are not undone.

## Timing
- Reset values: `acc_ready`=0, `wre`=0, `write_address`=0, `write_data`=0, `busy`=0, `done`=0.
- Accept at edge t -> FIFO entry after t; with `wr_grant`=1, write registered at edge t+1 (`wre` high in cycle t+1..t+2). Minimum latency 2 cycles.
- Sustained throughput 1 result/cycle with continuous grant.
- Last write registered at edge w -> state DONE after w, `done` high during cycle following edge w+1; `busy` low one cycle later.
- `Nk`=0: `start` at edge s -> `done` high after edge s+1, no `wre`.
- Address wrap: base=250, `Nk`=10 -> addresses 250..255, 0..3.

## Structure
- Package `neuron_wb_pkg`: state enum, activation function (shift/ReLU/saturate), default parameter constants.
- Sub-module `wb_fifo`: synchronous FIFO with push/pop/full/empty/head, DEPTH entries, pointer wrap.

## Test plan
- base=10, Nk=3, data 0x0100, 0xFF00, 0x7FFF, grant=1 -> writes (10,16),(11,0),(12,127), `done` once.
- Grant held low while 4 results arrive -> `acc_ready` drops after 4th; grant high -> 4 consecutive writes, then remaining accepted.
- base=254, Nk=4 -> addresses 254,255,0,1.
- Nk=0 start -> `done` 2 cycles later, no `wre`; `start` during ACTIVE ignored.
- `reset` low after 2 of 5 writes -> all outputs reset values, new start at base=20 writes from address 20.
